// File: rtl/positron_layer_sequencer_pkg.sv
// Shared definitions for the positron layer sequencer: FSM state encoding and
// the address-width helper.
package posit_defines;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STREAM  = 2'd1,
      ST_COLLECT = 2'd2,
      ST_DONE    = 2'd3
   } seq_state_e;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int unsigned log2(input int unsigned n);
      int unsigned r;
      r = 1;
      while ((r < 32) && ((32'd1 << r) < n)) r++;
      return r;
   endfunction

endpackage

// File: rtl/positron_layer_sequencer_if.sv
// Valid/ready word channel; carries the skid head (index + posit) to the sequencer.
interface positron_layer_sequencer_if #(
   parameter int unsigned DW = 8
);
   logic          valid;
   logic          ready;
   logic [DW-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/posit_skid_fifo.sv
// Small skid FIFO holding returned activation words until every positron is ready.
module posit_skid_fifo
   import posit_defines::*;
#(
   parameter  int unsigned DATA_WIDTH = 8,
   parameter  int unsigned DEPTH      = 2,
   localparam int unsigned PW         = log2(DEPTH),
   localparam int unsigned CW         = log2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   positron_layer_sequencer_if.master pop,
   output logic [CW-1:0]         count_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  pop_fire;

   assign pop_fire = pop.valid & pop.ready;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_fire);
      if (push_i)   wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
      if (pop_fire) rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: the count gates visibility.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= push_data_i;
   end

   assign pop.valid = (cnt_q != '0);
   assign pop.data  = mem_q[rd_q];
   assign count_o   = cnt_q;

endmodule

// File: rtl/positron_layer_sequencer.sv
// Streams one activation vector to a layer of positrons and gathers their results.
module positron_layer_sequencer
   import posit_defines::*;
#(
   parameter int unsigned POSIT_WIDTH = 4,
   parameter int unsigned NB_INPUTS   = 784,
   parameter int unsigned NB_NEURONS  = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start_i,
   output logic                              busy_o,
   output logic                              done_o,
   output logic                              act_rd_en_o,
   output logic [log2(NB_INPUTS)-1:0]        act_addr_o,
   input  logic [POSIT_WIDTH-1:0]            act_data_i,
   output logic                              pos_rts_o,
   output logic                              pos_sow_o,
   output logic                              pos_eow_o,
   output logic [POSIT_WIDTH-1:0]            pos_posit_o,
   input  logic [NB_NEURONS-1:0]             pos_rtr_i,
   input  logic [NB_NEURONS-1:0]             neur_rts_i,
   input  logic [NB_NEURONS*POSIT_WIDTH-1:0] neur_posit_i,
   output logic                              neur_rtr_o,
   output logic [NB_NEURONS*POSIT_WIDTH-1:0] result_o
);

   localparam int unsigned AW  = log2(NB_INPUTS);
   localparam int unsigned IW  = log2(NB_INPUTS + 1);
   localparam int unsigned SKW = AW + POSIT_WIDTH;
   localparam int unsigned RW  = NB_NEURONS * POSIT_WIDTH;
   localparam int unsigned CW  = log2(3);
   localparam int unsigned PDW = CW + 1;

   seq_state_e            state_q, state_d;
   logic [IW-1:0]         rd_idx_q, rd_idx_d;
   logic                  infl_q, infl_d;
   logic [AW-1:0]         infl_idx_q, infl_idx_d;
   logic [NB_NEURONS-1:0] flags_q, flags_d;
   logic [RW-1:0]         result_q, result_d;
   logic                  rd_en;
   logic [AW-1:0]         rd_addr;
   logic [CW-1:0]         skid_cnt;
   logic [AW-1:0]         head_idx;
   logic                  accept;
   logic [PDW-1:0]        pending;

   positron_layer_sequencer_if #(.DW(SKW)) head_if ();

   posit_skid_fifo #(.DATA_WIDTH(SKW), .DEPTH(2)) u_skid (
      .clk         (clk),
      .rst         (rst),
      .push_i      (infl_q),
      .push_data_i ({infl_idx_q, act_data_i}),
      .pop         (head_if),
      .count_o     (skid_cnt)
   );

   assign head_idx       = head_if.data[SKW-1:POSIT_WIDTH];
   assign head_if.ready  = (state_q == ST_STREAM) & (&pos_rtr_i);
   assign accept         = head_if.valid & head_if.ready;
   // Slots still committed after this cycle's pop; a new read needs one free.
   assign pending        = PDW'(skid_cnt) + PDW'(infl_q) - PDW'(accept);

   always_comb begin
      state_d    = state_q;
      rd_idx_d   = rd_idx_q;
      flags_d    = flags_q;
      result_d   = result_q;
      rd_en      = 1'b0;
      rd_addr    = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d  = ST_STREAM;
               flags_d  = '0;
               rd_en    = 1'b1;
               rd_idx_d = IW'(1);
            end
         end
         ST_STREAM: begin
            if ((rd_idx_q < IW'(NB_INPUTS)) && (pending < PDW'(2))) begin
               rd_en    = 1'b1;
               rd_addr  = AW'(rd_idx_q);
               rd_idx_d = rd_idx_q + IW'(1);
            end
            if (accept && (head_idx == AW'(NB_INPUTS - 1))) state_d = ST_COLLECT;
         end
         ST_COLLECT: begin
            for (int j = 0; j < int'(NB_NEURONS); j++) begin
               if (neur_rts_i[j] && !flags_q[j]) begin
                  result_d[j*POSIT_WIDTH +: POSIT_WIDTH] = neur_posit_i[j*POSIT_WIDTH +: POSIT_WIDTH];
                  flags_d[j] = 1'b1;
               end
            end
            if (&flags_d) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      infl_d     = rd_en;
      infl_idx_d = rd_addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rd_idx_q   <= '0;
         infl_q     <= 1'b0;
         infl_idx_q <= '0;
         flags_q    <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         rd_idx_q   <= rd_idx_d;
         infl_q     <= infl_d;
         infl_idx_q <= infl_idx_d;
         flags_q    <= flags_d;
         result_q   <= result_d;
      end
   end

   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = (state_q == ST_DONE);
   assign neur_rtr_o  = (state_q == ST_COLLECT);
   assign act_rd_en_o = rd_en;
   assign act_addr_o  = rd_addr;
   assign pos_rts_o   = head_if.valid;
   assign pos_posit_o = head_if.data[POSIT_WIDTH-1:0];
   assign pos_sow_o   = head_if.valid && (head_idx == '0);
   assign pos_eow_o   = head_if.valid && (head_idx == AW'(NB_INPUTS - 1));
   assign result_o    = result_q;

endmodule

// File: tb/tb_positron_layer_sequencer.sv
// Directed-plus-random bench for positron_layer_sequencer with a queue-based stream model.
module tb_positron_layer_sequencer;

   localparam int unsigned PW = 4;
   localparam int unsigned NI = 4;
   localparam int unsigned NN = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic          busy_o, done_o, act_rd_en_o;
   logic [1:0]    act_addr_o;
   logic [PW-1:0] act_data_i;
   logic          pos_rts_o, pos_sow_o, pos_eow_o;
   logic [PW-1:0] pos_posit_o;
   logic [NN-1:0] pos_rtr_i, neur_rts_i;
   logic [7:0]    neur_posit_i;
   logic          neur_rtr_o;
   logic [7:0]    result_o;

   logic [PW-1:0] buf_mem [NI];
   logic [7:0]    exp_result;
   int            n_pass   = 0;
   int            n_checks = 0;
   bit            ab;

   always #5 clk = ~clk;

   positron_layer_sequencer #(.POSIT_WIDTH(PW), .NB_INPUTS(NI), .NB_NEURONS(NN)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
      .act_rd_en_o(act_rd_en_o), .act_addr_o(act_addr_o), .act_data_i(act_data_i),
      .pos_rts_o(pos_rts_o), .pos_sow_o(pos_sow_o), .pos_eow_o(pos_eow_o),
      .pos_posit_o(pos_posit_o), .pos_rtr_i(pos_rtr_i), .neur_rts_i(neur_rts_i),
      .neur_posit_i(neur_posit_i), .neur_rtr_o(neur_rtr_o), .result_o(result_o)
   );

   positron_layer_sequencer_if #(.DW(6)) mon_if ();
   assign mon_if.valid = pos_rts_o;
   assign mon_if.data  = {pos_sow_o, pos_eow_o, pos_posit_o};
   assign mon_if.ready = &pos_rtr_i;

   // Activation buffer: data one cycle after the strobe, junk otherwise.
   always @(posedge clk) act_data_i <= act_rd_en_o ? buf_mem[act_addr_o] : 4'($urandom);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic reset_checks();
      check("rst_busy",   busy_o,      0);
      check("rst_done",   done_o,      0);
      check("rst_rd_en",  act_rd_en_o, 0);
      check("rst_rts",    pos_rts_o,   0);
      check("rst_sow",    pos_sow_o,   0);
      check("rst_eow",    pos_eow_o,   0);
      check("rst_nrtr",   neur_rtr_o,  0);
      check("rst_addr",   act_addr_o,  0);
      check("rst_result", result_o,    0);
   endtask

   // mode 0: all ready, 1: hold word 0x2 with rtr=01 for 3 cycles, 2: random rtr
   task automatic stream_pass(input int mode, input int abort_after, output bit aborted);
      logic [PW-1:0] exp_q[$];
      logic [5:0]    prev_data;
      bit            prev_pend;
      int k, idx, n_acc, hold, first_seen, first_acc, last_acc;
      exp_q.delete();
      for (int i = 0; i < int'(NI); i++) exp_q.push_back(buf_mem[i]);
      k = 0; idx = 0; n_acc = 0; hold = 0;
      first_seen = -1; first_acc = -1; last_acc = -1;
      prev_pend = 1'b0; prev_data = '0; aborted = 1'b0;
      while (idx < int'(NI) && k < 100) begin
         @(negedge clk);
         start_i = (k == 0);
         case (mode)
            0: pos_rtr_i = 2'b11;
            1: begin
               if (pos_rts_o && pos_posit_o == 4'h2 && hold < 3) begin
                  pos_rtr_i = 2'b01;
                  hold++;
               end else pos_rtr_i = 2'b11;
            end
            default: pos_rtr_i = 2'($urandom_range(0, 3));
         endcase
         neur_rts_i   = 2'($urandom_range(0, 3));
         neur_posit_i = 8'($urandom);
         #1;
         if (k > 0) check("busy_stream", busy_o, 1);
         check("nrtr_stream", neur_rtr_o, 0);
         if (prev_pend) check("hold_stable", {pos_rts_o, mon_if.data}, {1'b1, prev_data});
         if (pos_rts_o) begin
            if (first_seen < 0) first_seen = k;
            if (exp_q.size() == 0) check("extra_word", pos_rts_o, 0);
            else begin
               check("word", pos_posit_o, exp_q[0]);
               check("sow",  pos_sow_o,   idx == 0);
               check("eow",  pos_eow_o,   idx == int'(NI) - 1);
               if (&pos_rtr_i) begin
                  void'(exp_q.pop_front());
                  idx++; n_acc++;
                  if (first_acc < 0) first_acc = k;
                  last_acc = k;
               end
            end
         end
         prev_pend = pos_rts_o && !(&pos_rtr_i);
         prev_data = mon_if.data;
         if (abort_after > 0 && n_acc == abort_after) begin
            aborted = 1'b1;
            return;
         end
         k++;
      end
      check("stream_complete", idx, NI);
      if (mode == 0) begin
         check("latency",   first_seen,          2);
         check("burst_len", last_acc - first_acc, NI - 1);
      end
      if (mode == 1) check("hold_cycles", hold, 3);
      check("result_kept", result_o, exp_result);
   endtask

   task automatic collect(input bit directed, input bit poke_start);
      logic [PW-1:0] cap [NN];
      logic [1:0]    dm  [3];
      logic [7:0]    dd  [3];
      bit   [NN-1:0] fl;
      int k, dones;
      dm = '{2'b10, 2'b10, 2'b01};
      dd = '{8'hA7, 8'h3C, 8'h95};
      fl = '0; k = 0; dones = 0;
      for (int j = 0; j < int'(NN); j++) cap[j] = '0;
      while (fl != '1 && k < 50) begin
         @(negedge clk);
         start_i   = poke_start && (k == 0);
         pos_rtr_i = 2'($urandom);
         if (directed && k < 3) begin
            neur_rts_i   = dm[k];
            neur_posit_i = dd[k];
         end else begin
            neur_rts_i   = 2'($urandom_range(0, 3));
            neur_posit_i = 8'($urandom);
         end
         #1;
         check("nrtr_collect", neur_rtr_o, 1);
         check("done_early",   done_o,     0);
         check("no_word",      pos_rts_o,  0);
         for (int j = 0; j < int'(NN); j++)
            if (neur_rts_i[j] && !fl[j]) begin
               cap[j] = neur_posit_i[j*PW +: PW];
               fl[j]  = 1'b1;
            end
         k++;
      end
      check("collect_complete", fl, 2'b11);
      exp_result = {cap[1], cap[0]};
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         start_i      = 1'b0;
         neur_rts_i   = 2'b11;
         neur_posit_i = 8'($urandom);
         #1;
         check("done_pulse", done_o,     c == 0);
         check("busy_tail",  busy_o,     c == 0);
         check("nrtr_tail",  neur_rtr_o, 0);
         dones += int'(done_o);
         if (c > 0) check("result", result_o, exp_result);
      end
      check("done_count", dones, 1);
      if (directed) check("result_a5", result_o, 8'hA5);
   endtask

   initial begin
      buf_mem = '{4'h1, 4'h2, 4'h3, 4'h4};
      rst = 1'b1; start_i = 1'b0; pos_rtr_i = '0;
      neur_rts_i = '0; neur_posit_i = '0; exp_result = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      reset_checks();

      stream_pass(0, 0, ab);
      collect(1'b1, 1'b0);
      stream_pass(1, 0, ab);
      collect(1'b0, 1'b1);

      // Abort after the second accepted word.
      stream_pass(0, 2, ab);
      check("aborted", ab, 1);
      @(negedge clk);
      rst = 1'b1; start_i = 1'b0; pos_rtr_i = 2'b11;
      @(negedge clk);
      rst = 1'b0;
      #1;
      reset_checks();
      exp_result = '0;
      @(negedge clk);
      #1;
      check("drop_rts",  pos_rts_o,   0);
      check("drop_busy", busy_o,      0);
      check("drop_rd",   act_rd_en_o, 0);
      stream_pass(0, 0, ab);
      collect(1'b0, 1'b0);

      for (int p = 0; p < 6; p++) begin
         stream_pass(2, 0, ab);
         collect(1'b0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/positron_layer_sequencer.md
POSITRON_LAYER_SEQUENCER -- requirements
Module: positron_layer_sequencer

Interface
REQ-001 SHALL have parameter POSIT_WIDTH, default 4, posit word width.
REQ-002 SHALL have parameter NB_INPUTS, default 784, activations per input vector, which is also positron fan-in.
REQ-003 SHALL have parameter NB_NEURONS, default 16, positrons in the driven layer.
REQ-004 SHALL have ports:
  clk  in  1  clock, rising edge.
  rst  in  1  reset, synchronous and active-high.
  start_i  in  1  start one layer pass.
  busy_o  out  1  pass in progress.
  done_o  out  1  one-cycle pulse when result_o is valid.
  act_rd_en_o  out  1  activation buffer read strobe.
  act_addr_o  out  log2(NB_INPUTS)  activation buffer address.
  act_data_i  in  POSIT_WIDTH  read data, valid 1 cycle after act_rd_en_o.
  pos_rts_o  out  1  broadcast word valid to positrons.
  pos_sow_o  out  1  first word of vector.
  pos_eow_o  out  1  last word of vector.
  pos_posit_o  out  POSIT_WIDTH  broadcast activation.
  pos_rtr_i  in  NB_NEURONS  per-positron ready.
  neur_rts_i  in  NB_NEURONS  per-positron result valid.
  neur_posit_i  in  NB_NEURONS*POSIT_WIDTH  per-positron result; neuron j is at bits [j*POSIT_WIDTH +: POSIT_WIDTH].
  neur_rtr_o  out  1  sequencer ready for results.
  result_o  out  NB_NEURONS*POSIT_WIDTH  captured layer outputs.

Function
REQ-005 SHALL implement the FSM states IDLE, STREAM, COLLECT and DONE.
REQ-006 In IDLE, start_i=1 SHALL move the FSM to STREAM, clear the read index and the capture flags, and set busy_o=1 from the next cycle.
REQ-007 SHALL ignore start_i in any state other than IDLE.
REQ-008 In STREAM, a read SHALL be issued while the read index is below NB_INPUTS and (skid occupancy + reads in flight) < 2; each read increments the read index.
REQ-009 Returned act_data_i SHALL be pushed into the 2-entry skid buffer together with its index.
REQ-010 pos_rts_o SHALL equal skid-not-empty; pos_posit_o SHALL show the skid head.
REQ-011 A word SHALL be accepted when pos_rts_o & (&pos_rtr_i); accept pops the skid.
REQ-012 With all pos_rtr_i held high, throughput SHALL be one word per cycle after a 2-cycle start-up latency from start_i.
REQ-013 pos_sow_o SHALL be 1 only with head index 0; pos_eow_o SHALL be 1 only with head index NB_INPUTS-1; both SHALL be 1 together if NB_INPUTS=1.
REQ-014 Head word, sow and eow SHALL stay stable while pos_rts_o=1 and the word is not accepted.
REQ-015 Acceptance of the eow word SHALL move the FSM to COLLECT.
REQ-016 In COLLECT, neur_rtr_o SHALL be 1; neur_rtr_o SHALL be 0 in all other states.
REQ-017 In COLLECT, for each j with neur_rts_i[j]=1 and capture flag j clear, slice j of result_o SHALL be loaded and flag j set.
REQ-018 Repeat neur_rts_i[j] pulses after flag j is set SHALL be ignored.
REQ-019 Results arriving in the same cycle for several neurons SHALL all be captured that cycle.
REQ-020 When all flags are set, the FSM SHALL go to DONE; DONE SHALL assert done_o for exactly one cycle and then return to IDLE with busy_o=0.
REQ-021 neur_rts_i seen outside COLLECT SHALL be ignored.
REQ-022 result_o SHALL hold its value from DONE until the next capture.

Reset
REQ-023 When rst=1 at a clock edge, the FSM SHALL go to IDLE, the skid buffer and in-flight count SHALL empty, and flags and read index SHALL clear.
REQ-024 After reset, busy_o, done_o, act_rd_en_o, pos_rts_o, pos_sow_o, pos_eow_o, neur_rtr_o and act_addr_o SHALL be 0, and result_o SHALL be all-zero.
REQ-025 Reset mid-pass SHALL abort the pass; read data returning after reset SHALL be dropped.

Structure
REQ-026 The FSM state enum and the log2 function SHALL reside in posit_defines.
REQ-027 The skid buffer SHALL be a separate sub-module, posit_skid_fifo, with parameters DATA_WIDTH and DEPTH=2.

Verification
Parameters for all scenarios: POSIT_WIDTH=4, NB_INPUTS=4, NB_NEURONS=2. Buffer contents: {0x1,0x2,0x3,0x4}.
REQ-028 Start with all rtr high -> words 1,2,3,4 on consecutive cycles; sow on 0x1, eow on 0x4; busy_o=1 throughout.
REQ-029 pos_rtr_i=2'b01 for 3 cycles during word 0x2 -> 0x2 is held stable and no word is lost or duplicated.
REQ-030 neur_rts_i=2'b10 with data 0xA, then 2'b01 with 0x5 -> result_o=0xA5, single done_o pulse, then IDLE.
REQ-031 neur_rts_i=2'b11 during STREAM -> ignored; result_o unchanged.
REQ-032 rst after the 2nd accepted word -> all outputs 0 next cycle; a fresh start streams from 0x1 with sow.
REQ-033 start_i pulsed during COLLECT -> no effect; exactly one done_o.
